// File: rtl/waveform_loader_if.sv
// Bus bundle for the waveform loader: host byte stream in, write request
// handshake and packed 32-bit word stream out.
interface waveform_loader_if;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic         wf_write_ready;
  logic         init_wf_write;
  logic [127:0] waveform_parameters;
  logic [31:0]  wfin_axis_tdata;
  logic         wfin_axis_tvalid;
  logic         wfin_axis_tlast;
  logic [3:0]   wfin_axis_tkeep;
  logic         wfin_axis_tready;

  // Loader side of the bundle
  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, wf_write_ready, wfin_axis_tready,
    output s_axis_tready, init_wf_write, waveform_parameters,
           wfin_axis_tdata, wfin_axis_tvalid, wfin_axis_tlast, wfin_axis_tkeep
  );

  // Host / downstream side of the bundle
  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, wf_write_ready, wfin_axis_tready,
    input  s_axis_tready, init_wf_write, waveform_parameters,
           wfin_axis_tdata, wfin_axis_tvalid, wfin_axis_tlast, wfin_axis_tkeep
  );
endinterface

// File: rtl/waveform_loader.sv
// Waveform loader: packs a host byte stream into exactly size_q 32-bit words,
// requests the downstream write first, and pads or drains mismatched frames.
module waveform_loader #(
  parameter int unsigned MAX_WORDS     = 4096,
  parameter bit          LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk_in1,
  input  logic              aresetn,
  input  logic              load_start,
  input  logic [31:0]       load_size,
  waveform_loader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err_size,
  output logic              err_short,
  output logic              err_long
);

  typedef enum logic [2:0] {IDLE, REQ, PACK, PAD, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] size_q;
  logic [31:0] loadCnt_q;   // words placed into the output register so far
  logic [1:0]  byteIdx_q;
  logic [23:0] lane_q;      // bytes 0..2 of the word being assembled
  logic [31:0] outData_q;
  logic        outValid_q, outLast_q;
  logic        init_q, errSize_q, errShort_q, errLong_q, hostEnd_q;

  logic        sReady, byteAcc, packByte, loadWord, loadLast;
  logic [31:0] loadData;
  logic        startOk, startBad, setShort, setLong, drainLast;
  logic        outFree, lastWord;

  function automatic logic [31:0] packWord(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    if (LITTLE_ENDIAN) return {b3, b2, b1, b0};
    else               return {b0, b1, b2, b3};
  endfunction

  assign outFree  = !outValid_q || bus.wfin_axis_tready;
  assign lastWord = (loadCnt_q == size_q - 32'd1);

  // Next-state and per-cycle control decisions
  always_comb begin
    state_d   = state_q;
    sReady    = 1'b0;
    byteAcc   = 1'b0;
    packByte  = 1'b0;
    loadWord  = 1'b0;
    loadData  = 32'h0;
    loadLast  = 1'b0;
    startOk   = 1'b0;
    startBad  = 1'b0;
    setShort  = 1'b0;
    setLong   = 1'b0;
    drainLast = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if ((load_size != 32'd0) && (load_size <= MAX_WORDS)) begin
            startOk = 1'b1;
            state_d = REQ;
          end else begin
            startBad = 1'b1;
          end
        end
      end
      REQ: begin
        if (init_q && bus.wf_write_ready) state_d = PACK;
      end
      PACK: begin
        sReady  = (loadCnt_q != size_q) && ((byteIdx_q != 2'd3) || outFree);
        byteAcc = sReady && bus.s_axis_tvalid;
        if (byteAcc) begin
          if (byteIdx_q == 2'd3) begin
            loadWord = 1'b1;
            loadData = packWord(lane_q[7:0], lane_q[15:8], lane_q[23:16], bus.s_axis_tdata);
            loadLast = lastWord;
          end else begin
            packByte = 1'b1;
          end
          if ((byteIdx_q == 2'd3) && lastWord) begin
            if (!bus.s_axis_tlast) begin
              setLong = 1'b1;
              state_d = DRAIN;
            end
          end else if (bus.s_axis_tlast) begin
            setShort = 1'b1;
            state_d  = PAD;
          end
        end else if ((loadCnt_q == size_q) && outFree) begin
          state_d = DONE;
        end
      end
      PAD: begin
        if (loadCnt_q != size_q) begin
          if (outFree) begin
            loadWord = 1'b1;
            loadData = packWord(lane_q[7:0], lane_q[15:8], lane_q[23:16], 8'h00);
            loadLast = lastWord;
          end
        end else if (outFree) begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        // The final packed word may still be waiting for its handshake here
        sReady    = 1'b1;
        byteAcc   = bus.s_axis_tvalid;
        drainLast = byteAcc && bus.s_axis_tlast;
        if ((hostEnd_q || drainLast) && outFree) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath: size latch, byte lanes, output word register, request and error flags
  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      size_q     <= 32'h0;
      loadCnt_q  <= 32'h0;
      byteIdx_q  <= 2'd0;
      lane_q     <= 24'h0;
      outData_q  <= 32'h0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      init_q     <= 1'b0;
      errSize_q  <= 1'b0;
      errShort_q <= 1'b0;
      errLong_q  <= 1'b0;
      hostEnd_q  <= 1'b0;
    end else begin
      errSize_q <= startBad;
      if (startOk) begin
        size_q     <= load_size;
        loadCnt_q  <= 32'h0;
        byteIdx_q  <= 2'd0;
        lane_q     <= 24'h0;
        init_q     <= 1'b1;
        errShort_q <= 1'b0;
        errLong_q  <= 1'b0;
        hostEnd_q  <= 1'b0;
      end
      if ((state_q == REQ) && init_q && bus.wf_write_ready) init_q <= 1'b0;
      if (setShort)  errShort_q <= 1'b1;
      if (setLong)   errLong_q  <= 1'b1;
      if (drainLast) hostEnd_q  <= 1'b1;
      if (loadWord) begin
        outData_q  <= loadData;
        outLast_q  <= loadLast;
        outValid_q <= 1'b1;
        loadCnt_q  <= loadCnt_q + 32'd1;
        byteIdx_q  <= 2'd0;
        lane_q     <= 24'h0;
      end else begin
        if (outValid_q && bus.wfin_axis_tready) outValid_q <= 1'b0;
        if (packByte) begin
          case (byteIdx_q)
            2'd0:    lane_q[7:0]   <= bus.s_axis_tdata;
            2'd1:    lane_q[15:8]  <= bus.s_axis_tdata;
            2'd2:    lane_q[23:16] <= bus.s_axis_tdata;
            default: lane_q        <= lane_q;
          endcase
          byteIdx_q <= byteIdx_q + 2'd1;
        end
      end
    end
  end

  assign bus.s_axis_tready       = sReady;
  assign bus.init_wf_write       = init_q;
  assign bus.waveform_parameters = busy ? {96'h0, size_q} : 128'h0;
  assign bus.wfin_axis_tdata     = outData_q;
  assign bus.wfin_axis_tvalid    = outValid_q;
  assign bus.wfin_axis_tlast     = outLast_q;
  assign bus.wfin_axis_tkeep     = outValid_q ? 4'hF : 4'h0;
  assign busy                    = (state_q != IDLE);
  assign done                    = (state_q == DONE);
  assign err_size                = errSize_q;
  assign err_short               = errShort_q;
  assign err_long                = errLong_q;

endmodule

// File: tb/tb_waveform_loader.sv
// Bench for waveform_loader: table of directed loads, a randomized run checked
// against a frame-level model, and hand-written size-error and reset sequences.
module tb_waveform_loader;

  localparam int MAXW = 4096;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        load_start;
  logic [31:0] load_size;
  logic        busy, done, err_size, err_short, err_long;

  waveform_loader_if bus ();

  waveform_loader #(.MAX_WORDS(MAXW), .LITTLE_ENDIAN(1'b1)) dut (
    .clk_in1    (clk),
    .aresetn    (aresetn),
    .load_start (load_start),
    .load_size  (load_size),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err_size   (err_size),
    .err_short  (err_short),
    .err_long   (err_long)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Capture state filled by the monitor
  logic [31:0] gotWords[$];
  logic        gotLast[$];
  int          reqCount, doneCount, byteCount, errSizeCount, busySeen, initSeen;
  logic [31:0] gotParam;
  logic        paramHigh;
  logic        prevStall = 1'b0;
  logic [31:0] prevData;
  logic        prevLast;

  // Stimulus / model state
  int          readyMode = 0;
  int          phase = 0;
  logic [7:0]  frame[$];
  logic [31:0] expWords[$];
  logic        expShort, expLong;
  logic        sawShort, sawLong;

  typedef struct {
    int          size;
    int          nBytes;
    logic [7:0]  base;
    int          mode;
    logic        wantShort;
    logic        wantLong;
    int          wantWords;
    logic [31:0] wantFirst;
    logic [31:0] wantLast;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Frame-level reference: the first 4*size bytes of the host frame, zero padded
  function automatic void modelLoad(input int size);
    int n;
    logic [31:0] word;
    n = frame.size();
    expWords.delete();
    expShort = (n < 4 * size);
    expLong  = (n > 4 * size);
    for (int w = 0; w < size; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) word[8 * k +: 8] = frame[4 * w + k];
      expWords.push_back(word);
    end
  endfunction

  // Downstream and write-request ready generation
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: bus.wfin_axis_tready = 1'b1;
      1: begin
        bus.wfin_axis_tready = (phase == 0);
        phase = (phase + 1) % 4;
      end
      2: bus.wfin_axis_tready = 1'($urandom_range(0, 1));
      default: bus.wfin_axis_tready = 1'b0;
    endcase
    bus.wf_write_ready = (readyMode == 2) ? ($urandom_range(0, 2) == 0) : 1'b1;
  end

  // Monitor on the falling edge: handshakes, pulses, stall stability, tkeep
  always @(negedge clk) begin
    if (!aresetn) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("hold_valid", {31'h0, bus.wfin_axis_tvalid}, 32'h1);
        checkOutput("hold_data", bus.wfin_axis_tdata, prevData);
        checkOutput("hold_last", {31'h0, bus.wfin_axis_tlast}, {31'h0, prevLast});
      end
      if (bus.wfin_axis_tvalid) checkOutput("tkeep", {28'h0, bus.wfin_axis_tkeep}, 32'hF);
      if (bus.wfin_axis_tvalid && bus.wfin_axis_tready) begin
        gotWords.push_back(bus.wfin_axis_tdata);
        gotLast.push_back(bus.wfin_axis_tlast);
      end
      if (bus.init_wf_write && bus.wf_write_ready) begin
        reqCount++;
        gotParam  = bus.waveform_parameters[31:0];
        paramHigh = |bus.waveform_parameters[127:32];
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready) byteCount++;
      if (done) doneCount++;
      if (err_size) errSizeCount++;
      if (busy) busySeen++;
      if (bus.init_wf_write) initSeen++;
      prevStall = bus.wfin_axis_tvalid && !bus.wfin_axis_tready;
      prevData  = bus.wfin_axis_tdata;
      prevLast  = bus.wfin_axis_tlast;
    end
  end

  task automatic clearCapture();
    gotWords.delete();
    gotLast.delete();
    reqCount = 0; doneCount = 0; byteCount = 0; errSizeCount = 0; busySeen = 0; initSeen = 0;
  endtask

  // Present the bytes of 'frame', optionally with tlast on the final byte
  task automatic sendFrame(input bit withLast, input bit withGaps);
    int waited;
    for (int i = 0; i < frame.size(); i++) begin
      if (withGaps) begin
        bus.s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.s_axis_tdata  = frame[i];
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tlast  = withLast && (i == frame.size() - 1);
      waited = 0;
      forever begin
        @(negedge clk);
        if (bus.s_axis_tready) break;
        @(posedge clk); #1;
        waited++;
        if (waited > 500) break;
      end
      if (waited > 500) begin
        checkOutput("byte_timeout", 32'h1, 32'h0);
        break;
      end
      @(posedge clk); #1;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  // One full load: start, send the frame, wait for done, compare with the model
  task automatic applyStimulus(input int size, input bit withGaps);
    int n;
    clearCapture();
    n = frame.size();
    @(posedge clk); #1;
    load_start = 1'b1;
    load_size  = size;
    @(posedge clk); #1;
    load_start = 1'b0;
    sendFrame(1'b1, withGaps);
    for (int c = 0; c < 4000 && doneCount == 0; c++) begin @(posedge clk); #2; end
    if (doneCount == 0) checkOutput("done_timeout", 32'h0, 32'h1);
    @(negedge clk);
    sawShort = err_short;
    sawLong  = err_long;
    modelLoad(size);
    checkOutput("busy_after_done", {31'h0, busy}, 32'h0);
    checkOutput("req_count", reqCount, 32'd1);
    checkOutput("param_low", gotParam, size);
    checkOutput("param_high", {31'h0, paramHigh}, 32'h0);
    checkOutput("done_count", doneCount, 32'd1);
    checkOutput("byte_count", byteCount, n);
    checkOutput("err_size_quiet", errSizeCount, 32'd0);
    checkOutput("err_short", {31'h0, sawShort}, {31'h0, expShort});
    checkOutput("err_long", {31'h0, sawLong}, {31'h0, expLong});
    checkOutput("word_count", gotWords.size(), expWords.size());
    for (int i = 0; i < gotWords.size() && i < expWords.size(); i++) begin
      checkOutput($sformatf("word[%0d]", i), gotWords[i], expWords[i]);
      checkOutput($sformatf("tlast[%0d]", i), {31'h0, gotLast[i]}, {31'h0, (i == size - 1)});
    end
  endtask

  task automatic badSize(input logic [31:0] size);
    clearCapture();
    @(posedge clk); #1;
    load_start = 1'b1;
    load_size  = size;
    @(posedge clk); #1;
    load_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput($sformatf("err_size_pulse(%0d)", size), errSizeCount, 32'd1);
    checkOutput($sformatf("busy_stays_0(%0d)", size), busySeen, 32'd0);
    checkOutput($sformatf("no_init(%0d)", size), initSeen, 32'd0);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_tvalid"}, {31'h0, bus.wfin_axis_tvalid}, 32'h0);
    checkOutput({tag, "_init"}, {31'h0, bus.init_wf_write}, 32'h0);
    checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
    checkOutput({tag, "_done"}, {31'h0, done}, 32'h0);
    checkOutput({tag, "_s_tready"}, {31'h0, bus.s_axis_tready}, 32'h0);
    checkOutput({tag, "_params"}, {31'h0, |bus.waveform_parameters}, 32'h0);
    checkOutput({tag, "_errs"}, {29'h0, err_size, err_short, err_long}, 32'h0);
  endtask

  initial begin
    int size, kind, n;

    vecs[0] = '{size: 4, nBytes: 16, base: 8'h00, mode: 0, wantShort: 1'b0, wantLong: 1'b0,
                wantWords: 4, wantFirst: 32'h03020100, wantLast: 32'h0F0E0D0C};
    vecs[1] = '{size: 3, nBytes: 6, base: 8'hA1, mode: 0, wantShort: 1'b1, wantLong: 1'b0,
                wantWords: 3, wantFirst: 32'hA4A3A2A1, wantLast: 32'h00000000};
    vecs[2] = '{size: 2, nBytes: 12, base: 8'h10, mode: 0, wantShort: 1'b0, wantLong: 1'b1,
                wantWords: 2, wantFirst: 32'h13121110, wantLast: 32'h17161514};
    vecs[3] = '{size: 8, nBytes: 32, base: 8'h40, mode: 1, wantShort: 1'b0, wantLong: 1'b0,
                wantWords: 8, wantFirst: 32'h43424140, wantLast: 32'h5F5E5D5C};

    aresetn = 1'b0;
    load_start = 1'b0;
    load_size = 32'h0;
    bus.s_axis_tdata = 8'h0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    bus.wfin_axis_tready = 1'b1;
    bus.wf_write_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkQuiet("reset");
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Directed table
    for (int v = 0; v < 4; v++) begin
      frame.delete();
      for (int i = 0; i < vecs[v].nBytes; i++) frame.push_back(vecs[v].base + 8'(i));
      readyMode = vecs[v].mode;
      phase = 0;
      applyStimulus(vecs[v].size, 1'b0);
      checkOutput($sformatf("tbl%0d_words", v), gotWords.size(), vecs[v].wantWords);
      if (gotWords.size() > 0) begin
        checkOutput($sformatf("tbl%0d_first", v), gotWords[0], vecs[v].wantFirst);
        checkOutput($sformatf("tbl%0d_last", v), gotWords[gotWords.size() - 1], vecs[v].wantLast);
      end
      checkOutput($sformatf("tbl%0d_short", v), {31'h0, sawShort}, {31'h0, vecs[v].wantShort});
      checkOutput($sformatf("tbl%0d_long", v), {31'h0, sawLong}, {31'h0, vecs[v].wantLong});
    end

    // Rejected sizes
    readyMode = 0;
    badSize(32'd0);
    badSize(MAXW + 1);

    // Reset in the middle of a load, then a clean one-word load
    readyMode = 3;
    clearCapture();
    @(posedge clk); #1;
    load_start = 1'b1;
    load_size  = 32'd4;
    @(posedge clk); #1;
    load_start = 1'b0;
    frame.delete();
    for (int i = 0; i < 5; i++) frame.push_back(8'h70 + 8'(i));
    sendFrame(1'b0, 1'b0);
    aresetn = 1'b0;
    @(negedge clk);
    checkQuiet("midreset");
    @(posedge clk); #1;
    aresetn = 1'b1;
    readyMode = 0;
    @(negedge clk);
    checkOutput("post_reset_tvalid", {31'h0, bus.wfin_axis_tvalid}, 32'h0);
    frame.delete();
    for (int i = 0; i < 4; i++) frame.push_back(8'hC0 + 8'(i));
    applyStimulus(1, 1'b0);
    if (gotWords.size() > 0) checkOutput("clean_word", gotWords[0], 32'hC3C2C1C0);

    // Randomized loads with random gaps and random downstream/request readiness
    readyMode = 2;
    for (int t = 0; t < 16; t++) begin
      size = $urandom_range(1, 10);
      kind = $urandom_range(0, 2);
      if (kind == 0)      n = 4 * size;
      else if (kind == 1) n = $urandom_range(1, 4 * size - 1);
      else                n = 4 * size + $urandom_range(1, 7);
      frame.delete();
      for (int i = 0; i < n; i++) frame.push_back(8'($urandom_range(0, 255)));
      applyStimulus(size, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
